// File: rtl/axi_lite_sb_slave_pkg.sv
// Shared AXI-Lite widths/response codes (top_defines) and the slave's state, response and decode helpers.
// Combinational helpers only; no latency, no flow control.
`ifndef TOP_DEFINES_VH
`define TOP_DEFINES_VH
`define AXI_ADDR_WIDTH  32
`define AXI_DATA_WIDTH  32
`define AXI_STRB_WIDTH  4
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package axi_lite_sb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR_COLLECT = 2'd1,
    WR_RESP    = 2'd2,
    RD_RESP    = 2'd3
  } state_t;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY = `AXI_RESP_OKAY;

  // Offset is taken modulo 2^32, so addresses below the base wrap high and miss.
  function automatic logic addr_hit(input logic [`AXI_ADDR_WIDTH-1:0] addr,
                                    input logic [`AXI_ADDR_WIDTH-1:0] base,
                                    input int                         mem_aw);
    logic [`AXI_ADDR_WIDTH:0] offset;
    logic [`AXI_ADDR_WIDTH:0] span;
    offset = {1'b0, addr - base};
    span   = (`AXI_ADDR_WIDTH+1)'(4) << mem_aw;
    return offset < span;
  endfunction

endpackage

// File: rtl/axi_slv_mem.sv
// Byte-enable word array: synchronous write, registered read (data valid the cycle after re).
// No flow control; contents are never reset.
module axi_slv_mem #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int BW = DW / 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [BW-1:0] wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BW; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_lite_sb_slave.sv
// Single-outstanding AXI-Lite slave over axi_slv_mem; B/R valid one cycle after the last handshake, held until ready.
// AXI_SLV_DECERR_EN: out-of-window accesses answer DECERR instead of OKAY (writes dropped, reads return 0 either way).
module axi_lite_sb_slave
  import axi_lite_sb_slave_pkg::*;
#(
  parameter int                         MEM_AW    = 10,
  parameter logic [`AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [`AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                   AWPROT,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [`AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [`AXI_STRB_WIDTH-1:0]   WSTRB,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [1:0]                   BRESP,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  input  logic [`AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                   ARPROT,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [`AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                   RRESP
);

`ifdef AXI_SLV_DECERR_EN
  localparam resp_t RESP_MISS = `AXI_RESP_DECERR;
`else
  localparam resp_t RESP_MISS = `AXI_RESP_OKAY;
`endif

  state_t                       state, state_nxt;
  logic                         aw_held, w_held;
  logic [`AXI_ADDR_WIDTH-1:0]   awaddr_q;
  logic [`AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [`AXI_STRB_WIDTH-1:0]   wstrb_q;
  resp_t                        bresp_q, rresp_q;
  logic                         rd_hit_q;

  logic                         aw_hs, w_hs, ar_hs;
  logic                         have_aw, have_w, wr_fire;
  logic [`AXI_ADDR_WIDTH-1:0]   wr_addr, wr_off, rd_off;
  logic [`AXI_DATA_WIDTH-1:0]   wr_data, mem_rdata;
  logic [`AXI_STRB_WIDTH-1:0]   wr_strb;
  logic                         wr_hit, rd_hit;
  logic                         unused_bits;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // The write fires on whichever cycle completes the AW/W pair, using live bus values for the late half.
  assign have_aw = aw_held | aw_hs;
  assign have_w  = w_held | w_hs;
  assign wr_fire = have_aw & have_w;

  assign wr_addr = aw_held ? awaddr_q : AWADDR;
  assign wr_data = w_held  ? wdata_q  : WDATA;
  assign wr_strb = w_held  ? wstrb_q  : WSTRB;

  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = ARADDR - BASE_ADDR;
  assign wr_hit = addr_hit(wr_addr, BASE_ADDR, MEM_AW);
  assign rd_hit = addr_hit(ARADDR, BASE_ADDR, MEM_AW);

  assign unused_bits = ^{AWPROT, ARPROT, wr_off, rd_off};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_fire)              state_nxt = WR_RESP;
        else if (aw_hs || w_hs)   state_nxt = WR_COLLECT;
        else if (ar_hs)           state_nxt = RD_RESP;
      end
      WR_COLLECT: if (wr_fire)    state_nxt = WR_RESP;
      WR_RESP:    if (BREADY)     state_nxt = IDLE;
      RD_RESP:    if (RREADY)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Write priority: AR is refused in IDLE whenever a write channel is active.
  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    ARREADY = 1'b0;
    BVALID  = 1'b0;
    RVALID  = 1'b0;
    if (!ARESET) begin
      case (state)
        IDLE: begin
          AWREADY = 1'b1;
          WREADY  = 1'b1;
          ARREADY = !AWVALID && !WVALID;
        end
        WR_COLLECT: begin
          AWREADY = !aw_held;
          WREADY  = !w_held;
        end
        WR_RESP: BVALID = 1'b1;
        RD_RESP: RVALID = 1'b1;
        default: ;
      endcase
    end
  end

  assign BRESP = bresp_q;
  assign RRESP = rresp_q;
  assign RDATA = (state == RD_RESP && rd_hit_q) ? mem_rdata : '0;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rd_hit_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_hit ? RESP_OKAY : RESP_MISS;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          awaddr_q <= AWADDR;
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= WDATA;
          wstrb_q <= WSTRB;
        end
      end
      if (ar_hs) begin
        rd_hit_q <= rd_hit;
        rresp_q  <= rd_hit ? RESP_OKAY : RESP_MISS;
      end
    end
  end

  axi_slv_mem #(
    .AW (MEM_AW),
    .DW (`AXI_DATA_WIDTH),
    .BW (`AXI_STRB_WIDTH)
  ) u_mem (
    .clk   (ACLK),
    .we    (wr_fire & wr_hit),
    .waddr (wr_off[MEM_AW+1:2]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (ar_hs),
    .raddr (rd_off[MEM_AW+1:2]),
    .rdata (mem_rdata)
  );

endmodule
